// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - byte-level handshake between the SPI byte engine and its command sequencer
interface spi_bus;
  logic [7:0] data_read;
  logic       read_valid;
  logic       can_write;
  logic [7:0] data_write;

  modport master (
    input  data_read,
    input  read_valid,
    input  can_write,
    output data_write
  );

  modport slave (
    output data_read,
    output read_valid,
    output can_write,
    input  data_write
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI byte stream to register read/write sequencer
// SPI_REG_CTRL_AUTOINC_EN: advance the register address after every data byte (burst access)
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter logic [7:0]  DUMMY  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  spi_bus.master            spi,
  input  logic              spi_select,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_RD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic [7:0]        data_write_q, data_write_d;

  assign cmd_addr = spi.data_read[ADDR_W-1:0];

`ifdef SPI_REG_CTRL_AUTOINC_EN
  assign addr_next = addr_q + ADDR_W'(1);
`else
  assign addr_next = addr_q;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_we_d     = 1'b0;
    reg_re_d     = 1'b0;
    // reg_rdata is valid the cycle after a read strobe
    rd_valid_d   = reg_re_q;
    data_write_d = data_write_q;

    case (state_q)
      ST_IDLE: begin
        data_write_d = DUMMY;
        if (spi_select) begin
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        if (spi.read_valid) begin
          addr_d = cmd_addr;
          if (spi.data_read[7]) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d    = ST_RD_DATA;
            reg_addr_d = cmd_addr;
            reg_re_d   = 1'b1;
          end
        end
      end

      ST_WR_DATA: begin
        if (spi.read_valid) begin
          reg_we_d    = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = spi.data_read;
          addr_d      = addr_next;
        end
      end

      ST_RD_DATA: begin
        if (rd_valid_q) begin
          data_write_d = reg_rdata;
        end
        if (spi.can_write) begin
          addr_d     = addr_next;
          reg_addr_d = addr_next;
          reg_re_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // End of frame: a write for a byte that completed this cycle still goes out,
    // but no new read is launched and the outgoing byte falls back to the filler.
    if (!spi_select) begin
      state_d      = ST_IDLE;
      reg_re_d     = 1'b0;
      data_write_d = DUMMY;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_re_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      data_write_q <= DUMMY;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_re_q     <= reg_re_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      data_write_q <= data_write_d;
    end
  end

  assign reg_addr       = reg_addr_q;
  assign reg_wdata      = reg_wdata_q;
  assign reg_we         = reg_we_q;
  assign reg_re         = reg_re_q;
  assign busy           = busy_q;
  assign spi.data_write = data_write_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl
module tb_spi_reg_ctrl;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              spi_select = 1'b0;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata = 8'h00;
  logic              busy;

  logic [7:0]  regs [0:127];
  logic [14:0] exp_wr [$];
  logic [14:0] obs_wr [$];
  logic [7:0]  exp_rd [$];
  int          checks = 0;
  int          errors = 0;
  int          overlap = 0;

  spi_bus spi ();

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .DUMMY(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi        (spi),
    .spi_select (spi_select),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // register file model: read data valid exactly one cycle after the strobe
  always @(posedge clk) if (reg_re === 1'b1) reg_rdata <= regs[reg_addr];

  always @(negedge clk) begin
    if (reg_we === 1'b1) obs_wr.push_back({reg_addr, reg_wdata});
    if (reg_we === 1'b1 && reg_re === 1'b1) overlap++;
  end

  function automatic logic [6:0] step(input logic [6:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
    return a + 7'd1;
`else
    return a;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi.data_read = b;
    spi.read_valid = 1'b1;
    tick;
    spi.read_valid = 1'b0;
    repeat (3) tick;
  endtask

  task automatic open_frame;
    spi_select = 1'b1;
    repeat (2) tick;
  endtask

  task automatic close_frame;
    spi_select = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_we got %h want 0", reg_we); end
    checks++; if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_re got %h want 0", reg_re); end
    checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL reset_addr got %h want 00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", reg_wdata); end
    checks++; if (spi.data_write !== 8'hFF) begin errors++; $display("FAIL reset_dw got %h want ff", spi.data_write); end
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_write;
    logic [14:0] e, o;
    open_frame;
    spi.can_write = 1'b1;
    @(negedge clk);
    checks++; if (spi.data_write !== 8'hFF) begin errors++; $display("FAIL cmd_cw_dw got %h want ff", spi.data_write); end
    tick;
    spi.can_write = 1'b0;
    exp_wr.push_back({7'h05, 8'h11});
    exp_wr.push_back({step(7'h05), 8'h22});
    send_byte(8'h85);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy got %h want 1", busy); end
    send_byte(8'h11);
    send_byte(8'h22);
    close_frame;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL write_missing got none want %h", e); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin errors++; $display("FAIL write_pulse got %h want %h", o, e); end
      end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL write_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
  endtask

  task automatic test_read;
    logic [6:0] a;
    logic [7:0] e;
    regs[3] = 8'hAA;
    regs[4] = 8'hBB;
    open_frame;
    a = 7'h03;
    exp_rd.push_back(regs[a]);
    send_byte(8'h03);
    for (int i = 0; i < 2; i++) begin
      spi.can_write = 1'b1;
      @(negedge clk);
      e = exp_rd.pop_front();
      checks++; if (spi.data_write !== e) begin errors++; $display("FAIL read_dw%0d got %h want %h", i, spi.data_write, e); end
      a = step(a);
      exp_rd.push_back(regs[a]);
      tick;
      spi.can_write = 1'b0;
      repeat (3) tick;
      if (i == 0) send_byte(8'h77);
    end
    exp_rd.delete();
    close_frame;
    checks++; if (spi.data_write !== 8'hFF) begin errors++; $display("FAIL read_end_dw got %h want ff", spi.data_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_end_busy got %h want 0", busy); end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL read_wr_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL we_re_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_wrap;
    logic [14:0] e, o;
    exp_wr.push_back({7'h7F, 8'h12});
    exp_wr.push_back({step(7'h7F), 8'h34});
    open_frame;
    send_byte(8'hFF);
    send_byte(8'h12);
    send_byte(8'h34);
    close_frame;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL wrap_missing got none want %h", e); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin errors++; $display("FAIL wrap_pulse got %h want %h", o, e); end
      end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL wrap_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
  endtask

  task automatic test_drop_select;
    open_frame;
    send_byte(8'h81);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_pre got %h want 1", busy); end
    close_frame;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %h want 0", busy); end
    checks++; if (spi.data_write !== 8'hFF) begin errors++; $display("FAIL drop_dw got %h want ff", spi.data_write); end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL drop_we got %0d want 0", obs_wr.size()); obs_wr.delete(); end
  endtask

  task automatic test_reset_mid_frame;
    logic [14:0] e, o;
    exp_wr.push_back({7'h02, 8'h33});
    open_frame;
    send_byte(8'h82);
    send_byte(8'h33);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %h want 0", busy); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %h want 0", reg_we); end
    checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL rst_mid_addr got %h want 00", reg_addr); end
    tick;
    send_byte(8'h44);
    close_frame;
    exp_wr.push_back({7'h0A, 8'h55});
    open_frame;
    send_byte(8'h8A);
    send_byte(8'h55);
    close_frame;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL rst_mid_missing got none want %h", e); end
      else begin
        o = obs_wr.pop_front();
        if (o !== e) begin errors++; $display("FAIL rst_mid_pulse got %h want %h", o, e); end
      end
    end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL rst_mid_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'(i) ^ 8'h5A;
    spi.data_read = 8'h00;
    spi.read_valid = 1'b0;
    spi.can_write = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_drop_select;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
